// File: rtl/ps2_rx.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : ps2_rx
//  Description : PS/2 device-to-host receiver. Synchronises and glitch-filters
//                the PS/2 lines, deserialises the 11-bit frame, checks start,
//                parity and stop bits, and aborts stalled frames on timeout.
//  Revision    : 1.0 - initial release
// ============================================================================
module ps2_rx #(
  parameter int SYNC_STAGES    = 2,
  parameter int FILTER_CYCLES  = 8,
  parameter int TIMEOUT_CYCLES = 2518
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_dat,
  output logic [7:0] data,
  output logic       data_valid,
  output logic       error
);

  localparam int c_FILT_W = $clog2(FILTER_CYCLES + 1);
  localparam int c_TO_W   = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [c_FILT_W-1:0] c_FILT_LAST = c_FILT_W'(FILTER_CYCLES - 1);
  localparam logic [c_TO_W-1:0]   c_TO_LAST   = c_TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [c_TO_W-1:0]   c_TO_MAX    = c_TO_W'(TIMEOUT_CYCLES);

  localparam logic [1:0] c_ST_IDLE   = 2'd0;
  localparam logic [1:0] c_ST_DATA   = 2'd1;
  localparam logic [1:0] c_ST_PARITY = 2'd2;
  localparam logic [1:0] c_ST_STOP   = 2'd3;

  logic [SYNC_STAGES-1:0] r_clk_sync;
  logic [SYNC_STAGES-1:0] r_dat_sync;
  logic                   w_clk_s;
  logic                   w_dat_s;

  logic                   r_clk_f;
  logic                   r_clk_f_d;
  logic [c_FILT_W-1:0]    r_filt_cnt;
  logic                   r_fall;

  logic [1:0]             r_state;
  logic [1:0]             w_next_state;
  logic [2:0]             r_bit_cnt;
  logic [7:0]             r_shift;
  logic                   r_par;
  logic [c_TO_W-1:0]      r_to_cnt;
  logic [7:0]             r_data;
  logic                   r_data_valid;
  logic                   r_error;

  logic                   w_timeout;
  logic                   w_frame_ok;
  logic                   w_clr_bits;
  logic                   w_shift_en;
  logic                   w_par_en;
  logic                   w_load_data;
  logic                   w_frame_err;

  assign w_clk_s    = r_clk_sync[SYNC_STAGES-1];
  assign w_dat_s    = r_dat_sync[SYNC_STAGES-1];
  assign data       = r_data;
  assign data_valid = r_data_valid;
  assign error      = r_error;

  // Bring both PS/2 pins into the clk domain; lines idle high so flops reset to 1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_clk_sync <= '1;
      r_dat_sync <= '1;
    end else begin
      r_clk_sync <= {r_clk_sync[SYNC_STAGES-2:0], ps2_clk};
      r_dat_sync <= {r_dat_sync[SYNC_STAGES-2:0], ps2_dat};
    end
  end

  // Glitch filter: accept a new clock level only after it has held for FILTER_CYCLES cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_clk_f    <= 1'b1;
      r_filt_cnt <= '0;
    end else if (w_clk_s != r_clk_f) begin
      if (r_filt_cnt == c_FILT_LAST) begin
        r_clk_f    <= w_clk_s;
        r_filt_cnt <= '0;
      end else begin
        r_filt_cnt <= r_filt_cnt + c_FILT_W'(1);
      end
    end else begin
      r_filt_cnt <= '0;
    end
  end

  // Registered one-cycle pulse on each falling edge of the filtered clock.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_clk_f_d <= 1'b1;
      r_fall    <= 1'b0;
    end else begin
      r_clk_f_d <= r_clk_f;
      r_fall    <= r_clk_f_d & ~r_clk_f;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= c_ST_IDLE;
    else     r_state <= w_next_state;
  end

  // Timeout fires one cycle before the counter would reach the limit so the
  // error pulse lands TIMEOUT_CYCLES+1 cycles after the last detected fall.
  assign w_timeout = (r_state != c_ST_IDLE) && (r_to_cnt == c_TO_LAST);

  // FSM next-state logic; a timeout overrides any fall in the same cycle.
  always_comb begin
    w_next_state = r_state;
    if (w_timeout) begin
      w_next_state = c_ST_IDLE;
    end else if (r_fall) begin
      case (r_state)
        c_ST_IDLE:   if (!w_dat_s) w_next_state = c_ST_DATA;
        c_ST_DATA:   if (r_bit_cnt == 3'd7) w_next_state = c_ST_PARITY;
        c_ST_PARITY: w_next_state = c_ST_STOP;
        c_ST_STOP:   w_next_state = c_ST_IDLE;
        default:     w_next_state = c_ST_IDLE;
      endcase
    end
  end

  // FSM output strobes driving the datapath and the result pulses.
  always_comb begin
    w_frame_ok  = w_dat_s & (^{r_shift, r_par});
    w_clr_bits  = 1'b0;
    w_shift_en  = 1'b0;
    w_par_en    = 1'b0;
    w_load_data = 1'b0;
    w_frame_err = w_timeout;
    if (r_fall && !w_timeout) begin
      case (r_state)
        c_ST_IDLE:   w_clr_bits  = 1'b1;
        c_ST_DATA:   w_shift_en  = 1'b1;
        c_ST_PARITY: w_par_en    = 1'b1;
        c_ST_STOP: begin
          w_load_data = w_frame_ok;
          w_frame_err = ~w_frame_ok;
        end
        default: w_frame_err = 1'b0;
      endcase
    end
  end

  // Deserialiser: LSB-first shift, bit counter and parity capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_shift   <= '0;
      r_bit_cnt <= '0;
      r_par     <= 1'b0;
    end else begin
      if (w_clr_bits) r_bit_cnt <= '0;
      if (w_shift_en) begin
        r_shift   <= {w_dat_s, r_shift[7:1]};
        r_bit_cnt <= r_bit_cnt + 3'd1;
      end
      if (w_par_en) r_par <= w_dat_s;
    end
  end

  // Inter-edge timeout counter: idle-cleared, cleared on each fall, stops at the limit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_to_cnt <= '0;
    end else if ((r_state == c_ST_IDLE) || r_fall) begin
      r_to_cnt <= '0;
    end else if (r_to_cnt != c_TO_MAX) begin
      r_to_cnt <= r_to_cnt + c_TO_W'(1);
    end
  end

  // Output byte and result pulses, registered one cycle after the stop-bit fall.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_data       <= 8'h00;
      r_data_valid <= 1'b0;
      r_error      <= 1'b0;
    end else begin
      if (w_load_data) r_data <= r_shift;
      r_data_valid <= w_load_data;
      r_error      <= w_frame_err;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ps2_rx.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_ps2_rx
//  Description : Directed self-checking bench for ps2_rx with a frame-level
//                reference model and a per-cycle output compare.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ps2_rx;

  localparam int SYNC = 2;
  localparam int FILT = 8;
  localparam int TO   = 300;
  localparam int HALF = 100;
  localparam int LAT  = SYNC + FILT + 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ps2_clk = 1'b1;
  logic       ps2_dat = 1'b1;
  logic [7:0] data;
  logic       data_valid;
  logic       error;

  ps2_rx #(
    .SYNC_STAGES   (SYNC),
    .FILTER_CYCLES (FILT),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .ps2_clk   (ps2_clk),
    .ps2_dat   (ps2_dat),
    .data      (data),
    .data_valid(data_valid),
    .error     (error)
  );

  always #20 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int passed = 0;
  int total  = 0;

  // expected events: kind 1 = data_valid with byte, kind 2 = error
  int exp_kind[int];
  int exp_byte[int];

  int last_fall   = 0;
  int dv_cnt      = 0;
  int err_cnt     = 0;
  int last_dv_cyc = 0;
  int last_er_cyc = 0;
  logic [7:0] model_data;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d",
                  nm, act, act, exp, exp, cyc);
  endtask

  task automatic tick(input int k);
    repeat (k) @(posedge clk);
    #1;
  endtask

  // Drive the first nbits of a frame; outcome is scheduled right after the last fall.
  task automatic send_frame(input logic [7:0] b, input logic par, input logic stop,
                            input int nbits, input bit expect_timeout);
    logic [10:0] f;
    f = {stop, par, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      ps2_dat = f[i];
      tick(HALF / 2);
      ps2_clk = 1'b0;
      last_fall = cyc;
      if (i == nbits - 1) begin
        if (nbits == 11) begin
          if (stop && ((^b) ^ par)) begin
            exp_kind[last_fall + LAT] = 1;
            exp_byte[last_fall + LAT] = int'(b);
          end else begin
            exp_kind[last_fall + LAT] = 2;
          end
        end else if (expect_timeout) begin
          exp_kind[last_fall + LAT + TO] = 2;
        end
      end
      tick(HALF);
      ps2_clk = 1'b1;
      tick(HALF / 2);
    end
    ps2_dat = 1'b1;
  endtask

  // Per-cycle compare of all outputs against the model.
  initial begin
    bit edv, eer;
    model_data = 8'h00;
    forever begin
      @(negedge clk);
      if (rst) begin
        model_data = 8'h00;
        edv = 1'b0;
        eer = 1'b0;
      end else begin
        edv = exp_kind.exists(cyc) && (exp_kind[cyc] == 1);
        eer = exp_kind.exists(cyc) && (exp_kind[cyc] == 2);
        if (edv) model_data = 8'(exp_byte[cyc]);
      end
      chk("data_valid", int'(data_valid), int'(edv));
      chk("error", int'(error), int'(eer));
      chk("data", int'(data), int'(model_data));
      if (data_valid) begin dv_cnt++; last_dv_cyc = cyc; end
      if (error)      begin err_cnt++; last_er_cyc = cyc; end
    end
  end

  initial begin
    int d0, e0;
    rst = 1'b1;
    tick(5);
    chk("reset_data", int'(data), 8'h00);
    chk("reset_valid", int'(data_valid), 0);
    chk("reset_error", int'(error), 0);
    rst = 1'b0;
    tick(5);

    // T1 good frame 1C
    d0 = dv_cnt; e0 = err_cnt;
    send_frame(8'h1C, 1'b0, 1'b1, 11, 1'b0);
    tick(20);
    chk("t1_valid_count", dv_cnt - d0, 1);
    chk("t1_error_count", err_cnt - e0, 0);
    chk("t1_data", int'(data), 8'h1C);
    chk("t1_latency", last_dv_cyc - last_fall, 12);

    // T2 parity error
    d0 = dv_cnt; e0 = err_cnt;
    send_frame(8'h1C, 1'b1, 1'b1, 11, 1'b0);
    tick(20);
    chk("t2_error_count", err_cnt - e0, 1);
    chk("t2_valid_count", dv_cnt - d0, 0);
    chk("t2_data", int'(data), 8'h1C);
    chk("t2_latency", last_er_cyc - last_fall, 12);

    // T3 bad stop, then good F0
    d0 = dv_cnt; e0 = err_cnt;
    send_frame(8'hF0, 1'b1, 1'b0, 11, 1'b0);
    tick(20);
    chk("t3_bad_stop_error", err_cnt - e0, 1);
    chk("t3_bad_stop_valid", dv_cnt - d0, 0);
    d0 = dv_cnt; e0 = err_cnt;
    send_frame(8'hF0, 1'b1, 1'b1, 11, 1'b0);
    tick(20);
    chk("t3_good_valid", dv_cnt - d0, 1);
    chk("t3_good_error", err_cnt - e0, 0);
    chk("t3_data", int'(data), 8'hF0);

    // T4 glitch on clock while idle, then good 1C
    d0 = dv_cnt; e0 = err_cnt;
    ps2_clk = 1'b0;
    tick(3);
    ps2_clk = 1'b1;
    tick(60);
    chk("t4_glitch_pulses", (dv_cnt - d0) + (err_cnt - e0), 0);
    send_frame(8'h1C, 1'b0, 1'b1, 11, 1'b0);
    tick(20);
    chk("t4_valid_count", dv_cnt - d0, 1);
    chk("t4_data", int'(data), 8'h1C);

    // T5 timeout after start + 4 data bits, then good 1C
    d0 = dv_cnt; e0 = err_cnt;
    send_frame(8'h1C, 1'b0, 1'b1, 5, 1'b1);
    tick(TO + 10);
    chk("t5_error_count", err_cnt - e0, 1);
    chk("t5_valid_count", dv_cnt - d0, 0);
    chk("t5_timeout_latency", last_er_cyc - last_fall, 312);
    chk("t5_data_held", int'(data), 8'h1C);
    d0 = dv_cnt; e0 = err_cnt;
    send_frame(8'h1C, 1'b0, 1'b1, 11, 1'b0);
    tick(20);
    chk("t5_recover_valid", dv_cnt - d0, 1);
    chk("t5_recover_error", err_cnt - e0, 0);

    // T6 reset mid-frame, then good 5A
    d0 = dv_cnt; e0 = err_cnt;
    send_frame(8'h5A, 1'b1, 1'b1, 6, 1'b0);
    rst = 1'b1;
    tick(3);
    chk("t6_reset_data", int'(data), 8'h00);
    rst = 1'b0;
    tick(TO + 20);
    chk("t6_no_pulses", (dv_cnt - d0) + (err_cnt - e0), 0);
    chk("t6_data_after_reset", int'(data), 8'h00);
    send_frame(8'h5A, 1'b1, 1'b1, 11, 1'b0);
    tick(20);
    chk("t6_valid_count", dv_cnt - d0, 1);
    chk("t6_data", int'(data), 8'h5A);

    tick(5);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
